// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Parametrised Mealy serial-pattern detector. It watches a 1-bit serial stream,
//   one bit per clock with en=1, and raises dout in the same cycle that the last
//   pattern bit arrives. Matches may overlap or not, selected at run time.
//   PATTERN[PAT_LEN-1] is the first bit received and PATTERN[0] is the last.
//
//   State S is the number of pattern bits currently matched (0..PAT_LEN-1).
//   Every successor state comes from a table built at elaboration time. A
//   constant function computes the longest pattern prefix that is a suffix of
//   the bits seen so far, so the hardware holds only a small ROM-like mux and
//   never searches at run time.
//
//   Optional feature macro:
//     SEQDET_MATCH_CNT_EN  defined   -> saturating match counter on match_cnt
//                          undefined -> match_cnt tied to zero, detection unchanged
module seq_detector_param #(
    parameter int unsigned          PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]   PATTERN = 5'b11011,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             overlap,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    // State register width. Legal PAT_LEN is 2..16, so $clog2 returns 1..4.
    localparam int unsigned SW     = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    // The table is indexed by {state, din}. It is sized to the full index
    // range so that unreachable codes still read a defined value.
    localparam int unsigned TAB_N  = 2 ** (SW + 1);
    localparam logic [SW-1:0] LAST_S = SW'(PAT_LEN - 1);

    // Reject illegal configurations during elaboration.
    generate
        if ((PAT_LEN < 2) || (PAT_LEN > 16)) begin : g_bad_len
            $error("seq_detector_param: PAT_LEN must be in 2..16");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("seq_detector_param: CNT_W must be at least 1");
        end
    endgenerate

    // Return pattern bit number i in arrival order. Index 0 is the first bit received.
    function automatic logic pat_bit(input int i);
        return PATTERN[PAT_LEN - 1 - i];
    endfunction

    // Compute the successor state for state s and input bit d.
    // The string examined is the first s pattern bits followed by d. The result
    // is the longest prefix of PATTERN, shorter than the whole pattern, that
    // equals a suffix of that string. With this rule:
    //   - a matching bit below the last state returns s+1;
    //   - a mismatch returns the usual failure length;
    //   - a full match at the last state returns the KMP border B.
    function automatic int fail_len(input int s, input logic d);
        int   best;
        int   pos;
        logic ok;
        logic sb;
        best = 0;
        for (int k = 1; k <= s + 1; k++) begin
            if (k < int'(PAT_LEN)) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    pos = s + 1 - k + j;
                    sb  = (pos == s) ? d : pat_bit(pos);
                    if (sb != pat_bit(j)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

    // Constant successor table, entry index = {state, din}.
    logic [SW-1:0] nxt_tab [TAB_N];

    generate
        for (genvar gi = 0; gi < int'(TAB_N); gi++) begin : g_tab
            localparam int   S_IDX = gi / 2;
            localparam logic D_BIT = 1'(gi % 2);
            if (S_IDX < int'(PAT_LEN)) begin : g_used
                assign nxt_tab[gi] = SW'(fail_len(S_IDX, D_BIT));
            end else begin : g_unused
                assign nxt_tab[gi] = {SW{1'b0}};
            end
        end
    endgenerate

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] nxt_s;
    logic          hit_s;
    logic          dout_s;

    // Next-state selection and the same-cycle Mealy match flag.
    always_comb begin
        nxt_s   = nxt_tab[{state_q, din}];
        hit_s   = (state_q == LAST_S) && (din == PATTERN[0]);
        dout_s  = 1'b0;
        state_d = state_q;
        if (rst) begin
            // Reset suppresses the flag even when din and en would complete a match.
            dout_s  = 1'b0;
            state_d = state_q;
        end else if (en) begin
            dout_s = hit_s;
            if (hit_s) begin
                // overlap matters only on the match cycle itself.
                if (overlap) begin
                    state_d = nxt_s;
                end else begin
                    state_d = {SW{1'b0}};
                end
            end else begin
                state_d = nxt_s;
            end
        end else begin
            // A bubble holds state, and din is never looked at.
            dout_s  = 1'b0;
            state_d = state_q;
        end
    end

    // Match-progress state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= {SW{1'b0}};
        end else begin
            state_q <= state_d;
        end
    end

    assign dout = dout_s;

`ifdef SEQDET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count reported matches, and stick at all-ones rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (dout_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Match counter register. Reset takes priority over a same-edge match.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule
